ddr_req_arbiter: RTL

Sits between the capture-side requesters and ddr_memory_interface, and shares the single DDR2 command path between two requesters. The write requester is the dram_packer line stream. The read requester is the capture readback address stream. Each requester gets a one-entry holding slot. The block issues at most one command per cycle and gives writes priority so that no samples are lost, with a bounded-starvation guarantee for reads and a read-after-write address hazard check. It also exports command counters and an idle flag for status registers.

---
 rtl/ddr_arb_pkg.sv | 15 +
 rtl/ddr_req_slot.sv | 27 ++
 rtl/ddr_req_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR request arbiter.
package ddr_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 27;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned STARVE_W   = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/ddr_req_slot.sv
// One-entry holding register: load wins over clear so accept+issue reloads.
module ddr_req_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] payload
);

  // Slot state: valid flag plus captured payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      payload <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      payload <= din;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Shares the DDR command path between the write (packer) and read (readback)
// requesters: write priority, bounded read starvation, read-after-write hold.
module ddr_req_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned WR_BURST_MAX = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_req_in,
  input  logic [ADDR_W-1:0]   wr_adx_in,
  input  logic [DATA_W-1:0]   wr_data_in,
  output logic                wr_allowed_out,
  input  logic                rd_req_in,
  input  logic [ADDR_W-1:0]   rd_adx_in,
  output logic                rd_allowed_out,
  output logic                mem_write_req,
  output logic [ADDR_W-1:0]   mem_wr_adx,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic                mem_write_allowed,
  output logic                mem_read_req,
  output logic [ADDR_W-1:0]   mem_rd_adx,
  input  logic                mem_read_allowed,
  input  logic                mem_writes_pending,
  input  logic                mem_reads_pending,
  output logic                idle,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [STARVE_W-1:0] starve_count
);

  localparam int unsigned WR_PAY_W = ADDR_W + DATA_W;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(WR_BURST_MAX);

  logic                wr_valid;
  logic                rd_valid;
  logic [WR_PAY_W-1:0] wr_payload;
  logic [ADDR_W-1:0]   rd_payload;
  logic                wr_accept;
  logic                rd_accept;
  logic                wr_issue;
  logic                rd_issue;
  logic                wr_elig;
  logic                rd_elig;
  gnt_e                gnt;

  ddr_req_slot #(.W(WR_PAY_W)) u_wr_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (wr_accept),
    .clear   (wr_issue),
    .din     ({wr_adx_in, wr_data_in}),
    .valid   (wr_valid),
    .payload (wr_payload)
  );

  ddr_req_slot #(.W(ADDR_W)) u_rd_slot (
    .clk     (clk),
    .reset   (reset),
    .load    (rd_accept),
    .clear   (rd_issue),
    .din     (rd_adx_in),
    .valid   (rd_valid),
    .payload (rd_payload)
  );

  assign mem_wr_adx  = wr_payload[WR_PAY_W-1:DATA_W];
  assign mem_wr_data = wr_payload[DATA_W-1:0];
  assign mem_rd_adx  = rd_payload;

  // Eligibility; a read to the address of a held write waits for that write.
  assign wr_elig = wr_valid & mem_write_allowed;
  assign rd_elig = rd_valid & mem_read_allowed & ~(wr_valid && (mem_wr_adx == rd_payload));

  // Grant: write first unless the waiting read has hit its starvation bound.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (wr_elig && rd_elig) begin
        gnt = (starve_count == STARVE_MAX) ? GNT_RD : GNT_WR;
      end else if (wr_elig) begin
        gnt = GNT_WR;
      end else if (rd_elig) begin
        gnt = GNT_RD;
      end
    end
  end

  assign wr_issue      = (gnt == GNT_WR);
  assign rd_issue      = (gnt == GNT_RD);
  assign mem_write_req = wr_issue;
  assign mem_read_req  = rd_issue;

  // Slot frees in the same cycle it issues, giving one command per cycle per port.
  assign wr_allowed_out = ~wr_valid | wr_issue;
  assign rd_allowed_out = ~rd_valid | rd_issue;
  assign wr_accept      = wr_req_in & wr_allowed_out & ~reset;
  assign rd_accept      = rd_req_in & rd_allowed_out & ~reset;

  assign idle = ~wr_valid & ~rd_valid & ~mem_writes_pending & ~mem_reads_pending;

  // Write streak counter while a read waits; saturates at the burst bound.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_count <= '0;
    end else if (rd_issue || !rd_valid) begin
      starve_count <= '0;
    end else if (wr_issue && (starve_count != STARVE_MAX)) begin
      starve_count <= starve_count + STARVE_W'(1);
    end
  end

  // Issued-command counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_issue) wr_count <= wr_count + CNT_W'(1);
      if (rd_issue) rd_count <= rd_count + CNT_W'(1);
    end
  end

endmodule
